hd44780_responder: RTL

- Synthesizable responder for the HD44780-style 8-bit character-LCD bus (RS/RW/EN/DATA): the other end of the bus the LCD_Display writer drives.
- Captures command and data writes, maintains a 2x16 DDRAM image, and models the address counter, entry mode, display-on flag and busy timing.
- Answers busy-flag/address reads and data reads.
- Sits beside the writer in the system testbench, or inside the top on a loop-back path. The DDRAM image is readable through a side port for hex/LED debug.

---
 rtl/hd44780_pkg.sv | 34 +++
 rtl/hd44780_ac_step.sv | 28 ++
 rtl/hd44780_responder.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/hd44780_pkg.sv
// Shared constants for the HD44780 bus responder: command decode patterns,
// DDRAM geometry, the blank character and the controller state encoding.
package hd44780_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_BUSY = 2'd2
  } state_e;

  // Instruction decode, tested in this order so the first match from the MSB wins
  localparam logic [7:0] CMD_DDRAM_MASK = 8'h80, CMD_DDRAM = 8'h80;
  localparam logic [7:0] CMD_CGRAM_MASK = 8'hC0, CMD_CGRAM = 8'h40;
  localparam logic [7:0] CMD_FUNC_MASK  = 8'hE0, CMD_FUNC  = 8'h20;
  localparam logic [7:0] CMD_SHIFT_MASK = 8'hF0, CMD_SHIFT = 8'h10;
  localparam logic [7:0] CMD_DISP_MASK  = 8'hF8, CMD_DISP  = 8'h08;
  localparam logic [7:0] CMD_ENTRY_MASK = 8'hFC, CMD_ENTRY = 8'h04;
  localparam logic [7:0] CMD_HOME_MASK  = 8'hFE, CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_CLEAR_MASK = 8'hFF, CMD_CLEAR = 8'h01;

  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE_LEN   = 7'd16;
  localparam logic [6:0] LINE1_WRAP = 7'h27;
  localparam logic [6:0] LINE2_WRAP = 7'h67;
  localparam int unsigned DDRAM_DEPTH = 32;
  localparam logic [7:0] BLANK = 8'h20;

  function automatic logic cmd_match(input logic [7:0] data, input logic [7:0] mask,
                                     input logic [7:0] match);
    return (data & mask) == match;
  endfunction

endpackage

// File: rtl/hd44780_ac_step.sv
// Combinational address-counter helper: next AC for the current entry mode,
// plus whether AC is on-screen and its DDRAM image index.
module hd44780_ac_step
  import hd44780_pkg::*;
(
  input  logic [6:0] ac_i,
  input  logic       inc_i,
  output logic [6:0] ac_next_o,
  output logic       on_screen_o,
  output logic [4:0] index_o
);

  always_comb begin
    ac_next_o = inc_i ? (ac_i + 7'd1) : (ac_i - 7'd1);
    if (inc_i) begin
      if (ac_i == LINE1_WRAP) ac_next_o = LINE2_BASE;
      else if (ac_i == LINE2_WRAP) ac_next_o = LINE1_BASE;
    end else begin
      if (ac_i == LINE1_BASE) ac_next_o = LINE2_WRAP;
      else if (ac_i == LINE2_BASE) ac_next_o = LINE1_WRAP;
    end
  end

  // Both visible windows start on a 0x40 boundary, so bit 6 picks the line
  assign on_screen_o = {1'b0, ac_i[5:0]} < LINE_LEN;
  assign index_o     = {ac_i[6], ac_i[3:0]};

endmodule

// File: rtl/hd44780_responder.sv
// Responder side of an 8-bit HD44780 character-LCD bus: decodes writes into a
// 2x16 DDRAM image, models AC/entry mode/busy timing and answers bus reads.
module hd44780_responder
  import hd44780_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES      = 2000,
  parameter int unsigned LONG_BUSY_CYCLES = 82000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       lcd_en,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  input  logic [4:0] char_addr,
  output logic [7:0] char_data,
  output logic       busy,
  output logic       display_on,
  output logic       protocol_error
);

  localparam int unsigned MAX_CYCLES = (LONG_BUSY_CYCLES > BUSY_CYCLES) ? LONG_BUSY_CYCLES : BUSY_CYCLES;
  localparam int unsigned CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] BUSY_LD  = CW'(BUSY_CYCLES);
  localparam logic [CW-1:0] LONG_LD  = CW'(LONG_BUSY_CYCLES);
  localparam logic [CW-1:0] CLEAR_LD = CW'(LONG_BUSY_CYCLES - DDRAM_DEPTH);

  logic [10:0] sync1_q, sync2_q;
  logic        en_prev_q;
  logic [9:0]  cap_q;
  logic        en_s, rs_s, rw_s, en_fall;
  logic        cap_rs, cap_rw;
  logic [7:0]  cap_data;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [4:0]     fill_idx_q, fill_idx_d;
  logic           init_q, init_d;
  logic [6:0]     ac_q, ac_d;
  logic           inc_q, inc_d, disp_q, disp_d, cg_q, cg_d, perr_q, perr_d;

  logic           oe_q, rd_rs_q, rd_on_q;
  logic [7:0]     status_q, bus_rd_q, char_q;
  logic [7:0]     mem [DDRAM_DEPTH];
  logic           mem_we;
  logic [4:0]     mem_waddr;
  logic [7:0]     mem_wdata;

  logic [6:0]     ac_next;
  logic           ac_on_screen;
  logic [4:0]     ac_index;

  hd44780_ac_step u_ac_step (
    .ac_i       (ac_q),
    .inc_i      (inc_q),
    .ac_next_o  (ac_next),
    .on_screen_o(ac_on_screen),
    .index_o    (ac_index)
  );

  assign en_s     = sync2_q[10];
  assign rs_s     = sync2_q[9];
  assign rw_s     = sync2_q[8];
  assign en_fall  = en_prev_q & ~en_s;
  assign cap_rs   = cap_q[9];
  assign cap_rw   = cap_q[8];
  assign cap_data = cap_q[7:0];
  assign busy     = (state_q != ST_IDLE);

  // cap_q freezes on the last EN-high cycle, so it holds the fields seen just before the fall
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      en_prev_q <= 1'b0;
      cap_q     <= '0;
    end else begin
      sync1_q   <= {lcd_en, lcd_rs, lcd_rw, lcd_data_in};
      sync2_q   <= sync1_q;
      en_prev_q <= en_s;
      if (en_s) cap_q <= sync2_q[9:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_idx_d = fill_idx_q;
    init_d     = init_q;
    ac_d       = ac_q;
    inc_d      = inc_q;
    disp_d     = disp_q;
    cg_d       = cg_q;
    perr_d     = perr_q;
    mem_we     = 1'b0;
    mem_waddr  = fill_idx_q;
    mem_wdata  = BLANK;

    case (state_q)
      ST_IDLE: begin
        if (init_q) begin
          state_d    = ST_FILL;
          fill_idx_d = '0;
          cnt_d      = '0;
          init_d     = 1'b0;
        end
      end
      ST_FILL: begin
        mem_we     = 1'b1;
        fill_idx_d = fill_idx_q + 5'd1;
        if (fill_idx_q == 5'(DDRAM_DEPTH - 1))
          state_d = (cnt_q == '0) ? ST_IDLE : ST_BUSY;
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A completed transaction overrides whatever FILL/BUSY was doing
    if (en_fall) begin
      if (!cap_rw) begin
        perr_d  = perr_q | busy;
        mem_we  = 1'b0;
        state_d = ST_BUSY;
        cnt_d   = BUSY_LD;
        if (cap_rs) begin
          if (!cg_q) begin
            mem_we    = ac_on_screen;
            mem_waddr = ac_index;
            mem_wdata = cap_data;
            ac_d      = ac_next;
          end
        end else if (cmd_match(cap_data, CMD_DDRAM_MASK, CMD_DDRAM)) begin
          ac_d = cap_data[6:0];
          cg_d = 1'b0;
        end else if (cmd_match(cap_data, CMD_CGRAM_MASK, CMD_CGRAM)) begin
          cg_d = 1'b1;
        end else if (cmd_match(cap_data, CMD_FUNC_MASK, CMD_FUNC) ||
                     cmd_match(cap_data, CMD_SHIFT_MASK, CMD_SHIFT)) begin
          cg_d = cg_q;
        end else if (cmd_match(cap_data, CMD_DISP_MASK, CMD_DISP)) begin
          disp_d = cap_data[2];
        end else if (cmd_match(cap_data, CMD_ENTRY_MASK, CMD_ENTRY)) begin
          inc_d = cap_data[1];
        end else if (cmd_match(cap_data, CMD_HOME_MASK, CMD_HOME)) begin
          ac_d  = LINE1_BASE;
          cnt_d = LONG_LD;
        end else if (cmd_match(cap_data, CMD_CLEAR_MASK, CMD_CLEAR)) begin
          ac_d       = LINE1_BASE;
          inc_d      = 1'b1;
          state_d    = ST_FILL;
          fill_idx_d = '0;
          cnt_d      = CLEAR_LD;
        end
      end else if (cap_rs) begin
        perr_d = perr_q | busy;
        ac_d   = ac_next;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      fill_idx_q <= '0;
      init_q     <= 1'b1;
      ac_q       <= LINE1_BASE;
      inc_q      <= 1'b1;
      disp_q     <= 1'b0;
      cg_q       <= 1'b0;
      perr_q     <= 1'b0;
      oe_q       <= 1'b0;
      rd_rs_q    <= 1'b0;
      rd_on_q    <= 1'b0;
      status_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fill_idx_q <= fill_idx_d;
      init_q     <= init_d;
      ac_q       <= ac_d;
      inc_q      <= inc_d;
      disp_q     <= disp_d;
      cg_q       <= cg_d;
      perr_q     <= perr_d;
      oe_q       <= en_s & rw_s;
      rd_rs_q    <= rs_s;
      rd_on_q    <= ac_on_screen;
      status_q   <= {busy, ac_q};
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    bus_rd_q <= mem[ac_index];
  end

  always_ff @(posedge clock) begin
    if (reset) char_q <= BLANK;
    else       char_q <= mem[char_addr];
  end

  assign lcd_data_oe    = oe_q;
  assign lcd_data_out   = !oe_q ? 8'h00 : (!rd_rs_q ? status_q : (rd_on_q ? bus_rd_q : BLANK));
  assign char_data      = char_q;
  assign display_on     = disp_q;
  assign protocol_error = perr_q;

endmodule
